// File: rtl/alut_mp_pkg8.sv
// Shared types, command codes and helper functions for the multi-port ALUT engine.
package alut_mp_pkg8;

  // Widest configurations supported: 1024 entries, 8 ports, 64-bit time.
  localparam int HASH_MAX_W = 10;
  localparam int PORT_MAX_W = 3;
  localparam int TIME_MAX_W = 64;

  localparam logic [1:0] CMD_CLR_ALL  = 2'b01;
  localparam logic [1:0] CMD_INV_AGED = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LRN_RD,
    LRN_WR,
    LKP_RD,
    LKP_CHK,
    CLR,
    AGE_RD,
    AGE_WR
  } state_t;

  // Decoded table entry; narrower stored fields are zero-extended into this view.
  typedef struct packed {
    logic [47:0]           mac;
    logic [PORT_MAX_W-1:0] port;
    logic [TIME_MAX_W-1:0] ts;
  } entry_t;

  // XOR-fold of consecutive aw-bit slices; bit i of the MAC lands on bit (i mod aw),
  // which zero-pads the top slice automatically.
  function automatic logic [HASH_MAX_W-1:0] hash(input logic [47:0] m, input int aw);
    logic [HASH_MAX_W-1:0] h;
    h = '0;
    for (int i = 0; i < 48; i++) h[i % aw] = h[i % aw] ^ m[i];
    return h;
  endfunction

  // Wrap-safe age test: the difference is taken modulo 2^tw before comparing.
  function automatic logic aged(input logic [TIME_MAX_W-1:0] ts,
                                input logic [TIME_MAX_W-1:0] now,
                                input logic [TIME_MAX_W-1:0] max_age,
                                input int                    tw);
    logic [TIME_MAX_W-1:0] mask;
    mask = (tw >= TIME_MAX_W) ? '1 : ((TIME_MAX_W'(1) << tw) - TIME_MAX_W'(1));
    return ((now - ts) & mask) > max_age;
  endfunction

endpackage

// File: rtl/alut_mp_ram8.sv
// Single-port entry array with registered read (one-cycle latency).
module alut_mp_ram8 #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 82
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write on request, always register the addressed word.
  // NOTE: the array has no reset; entry validity lives in separate flops, so stale words are never trusted.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/alut_mp_engine8.sv
// Address lookup engine: source learning, destination lookup with inline aging,
// and clear / invalidate-aged table sweeps behind a valid/ready request port.
module alut_mp_engine8
  import alut_mp_pkg8::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH),
  parameter int PW        = $clog2(NUM_PORTS),
  parameter int TIME_W    = 32
) (
  input  logic               pclk8,
  input  logic               n_p_reset8,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [47:0]        req_daddr,
  input  logic [47:0]        req_saddr,
  input  logic [PW-1:0]      req_sport,
  input  logic [47:0]        mac_addr,
  input  logic [TIME_W-1:0]  best_bfr_age,
  input  logic [TIME_W-1:0]  curr_time,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_busy,
  input  logic               clear_reused,
  output logic               rsp_valid,
  output logic [NUM_PORTS:0] rsp_dport,
  output logic               rsp_reused,
  output logic               reused_sticky,
  output logic               lst_inv_valid,
  output logic               lst_inv_cmd,
  output logic [47:0]        lst_inv_addr,
  output logic [PW-1:0]      lst_inv_port
);

  localparam int                 DW       = 48 + PW + TIME_W;
  localparam logic [NUM_PORTS:0] SELF_BIT = {1'b1, {NUM_PORTS{1'b0}}};
  localparam logic [AW-1:0]      LAST_IDX = AW'(DEPTH - 1);

  state_t             state;
  logic [DEPTH-1:0]   valid;
  logic [47:0]        saddr_q;
  logic [47:0]        daddr_q;
  logic [PW-1:0]      sport_q;
  logic               reused_q;
  logic [AW-1:0]      idx;

  logic [AW-1:0]      s_idx;
  logic [AW-1:0]      d_idx;
  logic [AW-1:0]      ram_addr;
  logic               ram_we;
  logic [DW-1:0]      ram_wdata;
  logic [DW-1:0]      ram_rdata;
  entry_t             rd_e;
  logic               learn_en;
  logic               rd_aged;
  logic [NUM_PORTS:0] flood_mask;
  logic [NUM_PORTS:0] hit_mask;

  assign s_idx     = AW'(hash(saddr_q, AW));
  assign d_idx     = AW'(hash(daddr_q, AW));
  // Never learn our own MAC or a multicast source.
  assign learn_en  = (saddr_q != mac_addr) && !saddr_q[40];
  assign req_ready = (state == IDLE) && !cmd_valid;
  assign ram_we    = (state == LRN_WR) && learn_en;
  assign ram_wdata = {saddr_q, sport_q, curr_time};
  assign rd_aged   = aged(rd_e.ts, TIME_MAX_W'(curr_time), TIME_MAX_W'(best_bfr_age), TIME_W);

  alut_mp_ram8 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk   (pclk8),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Unpack the registered read word into the shared entry view.
  always_comb begin
    rd_e.mac  = ram_rdata[DW-1 -: 48];
    rd_e.port = PORT_MAX_W'(ram_rdata[TIME_W +: PW]);
    rd_e.ts   = TIME_MAX_W'(ram_rdata[TIME_W-1:0]);
  end

  // Select the table index for the current state.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    ram_addr = idx;
    case (state)
      LRN_RD, LRN_WR: ram_addr = s_idx;
      LKP_RD:         ram_addr = d_idx;
      default:        ram_addr = idx;
    endcase
  end

  // Flood mask excludes the source port; hit mask is the stored port one-hot.
  always_comb begin
    flood_mask = '0;
    hit_mask   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      flood_mask[p] = (PW'(p) != sport_q);
      hit_mask[p]   = (rd_e.port == PORT_MAX_W'(p));
    end
  end

  // Main control FSM with registered response, sweep and invalidation outputs.
  // NOTE: all state here uses <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge pclk8) begin
    if (!n_p_reset8) begin
      state         <= IDLE;
      valid         <= '0;
      idx           <= '0;
      saddr_q       <= '0;
      daddr_q       <= '0;
      sport_q       <= '0;
      reused_q      <= 1'b0;
      cmd_busy      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_dport     <= '0;
      rsp_reused    <= 1'b0;
      reused_sticky <= 1'b0;
      lst_inv_valid <= 1'b0;
      lst_inv_cmd   <= 1'b0;
      lst_inv_addr  <= '0;
      lst_inv_port  <= '0;
    end else begin
      rsp_valid     <= 1'b0;
      rsp_reused    <= 1'b0;
      lst_inv_valid <= 1'b0;
      // A set in LKP_CHK below lands later in the block, so it overrides this clear.
      if (clear_reused) reused_sticky <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd == CMD_CLR_ALL) begin
              state    <= CLR;
              cmd_busy <= 1'b1;
              idx      <= '0;
            end else if (cmd == CMD_INV_AGED) begin
              state    <= AGE_RD;
              cmd_busy <= 1'b1;
              idx      <= '0;
            end
          end else if (req_valid) begin
            saddr_q <= req_saddr;
            daddr_q <= req_daddr;
            sport_q <= req_sport;
            state   <= LRN_RD;
          end
        end

        LRN_RD: state <= LRN_WR;

        LRN_WR: begin
          reused_q <= learn_en && valid[s_idx] && (rd_e.mac != saddr_q);
          if (learn_en) valid[s_idx] <= 1'b1;
          state <= LKP_RD;
        end

        LKP_RD: state <= LKP_CHK;

        LKP_CHK: begin
          rsp_valid  <= 1'b1;
          rsp_reused <= reused_q;
          if (reused_q) reused_sticky <= 1'b1;
          if (daddr_q == mac_addr) begin
            rsp_dport <= SELF_BIT;
          end else if (&daddr_q) begin
            rsp_dport <= flood_mask;
          end else if (valid[d_idx] && (rd_e.mac == daddr_q) && !rd_aged) begin
            // Masking with the flood mask filters a hit back onto the source port.
            rsp_dport <= hit_mask & flood_mask;
          end else begin
            if (valid[d_idx] && (rd_e.mac == daddr_q)) begin
              valid[d_idx]  <= 1'b0;
              lst_inv_valid <= 1'b1;
              lst_inv_cmd   <= 1'b0;
              lst_inv_addr  <= rd_e.mac;
              lst_inv_port  <= rd_e.port[PW-1:0];
            end
            rsp_dport <= flood_mask;
          end
          state <= IDLE;
        end

        CLR: begin
          valid[idx] <= 1'b0;
          idx        <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            cmd_busy <= 1'b0;
          end
        end

        AGE_RD: state <= AGE_WR;

        AGE_WR: begin
          if (valid[idx] && rd_aged) begin
            valid[idx]    <= 1'b0;
            lst_inv_valid <= 1'b1;
            lst_inv_cmd   <= 1'b1;
            lst_inv_addr  <= rd_e.mac;
            lst_inv_port  <= rd_e.port[PW-1:0];
          end
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            cmd_busy <= 1'b0;
          end else begin
            state <= AGE_RD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alut_mp_engine8.sv
// Directed bench for alut_mp_engine8: table of request vectors plus sweep/reset sequences.
module tb_alut_mp_engine8;
  import alut_mp_pkg8::*;

  localparam int          NUM_PORTS = 4;
  localparam int          DEPTH     = 256;
  localparam int          PW        = 2;
  localparam int          TIME_W    = 32;
  localparam logic [47:0] MY_MAC    = 48'h0A0B_0C0D_0E0F;

  logic              pclk8;
  logic              n_p_reset8;
  logic              req_valid;
  logic              req_ready;
  logic [47:0]       req_daddr;
  logic [47:0]       req_saddr;
  logic [PW-1:0]     req_sport;
  logic [47:0]       mac_addr;
  logic [TIME_W-1:0] best_bfr_age;
  logic [TIME_W-1:0] curr_time;
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic              cmd_busy;
  logic              clear_reused;
  logic              rsp_valid;
  logic [NUM_PORTS:0] rsp_dport;
  logic              rsp_reused;
  logic              reused_sticky;
  logic              lst_inv_valid;
  logic              lst_inv_cmd;
  logic [47:0]       lst_inv_addr;
  logic [PW-1:0]     lst_inv_port;

  int checks = 0;
  int errors = 0;

  alut_mp_engine8 #(.NUM_PORTS(NUM_PORTS), .DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
    .pclk8         (pclk8),
    .n_p_reset8    (n_p_reset8),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_daddr     (req_daddr),
    .req_saddr     (req_saddr),
    .req_sport     (req_sport),
    .mac_addr      (mac_addr),
    .best_bfr_age  (best_bfr_age),
    .curr_time     (curr_time),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .cmd_busy      (cmd_busy),
    .clear_reused  (clear_reused),
    .rsp_valid     (rsp_valid),
    .rsp_dport     (rsp_dport),
    .rsp_reused    (rsp_reused),
    .reused_sticky (reused_sticky),
    .lst_inv_valid (lst_inv_valid),
    .lst_inv_cmd   (lst_inv_cmd),
    .lst_inv_addr  (lst_inv_addr),
    .lst_inv_port  (lst_inv_port)
  );

  initial pclk8 = 1'b0;
  always #5 pclk8 = ~pclk8;

  typedef struct {
    string         name;
    logic [47:0]   saddr;
    logic [PW-1:0] sport;
    logic [47:0]   daddr;
    logic [31:0]   ctime;
    logic [4:0]    dport;
    logic          reused;
    logic          inv;
    logic [47:0]   inv_addr;
    logic [PW-1:0] inv_port;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and watch an 8-cycle window for the response and invalidations.
  task automatic do_req(input logic [47:0] s, input logic [PW-1:0] sp, input logic [47:0] d,
                        input logic [31:0] t, output int lat, output logic [4:0] dp,
                        output logic reu, output int invs, output logic icmd,
                        output logic [47:0] iaddr, output logic [PW-1:0] iport);
    @(negedge pclk8);
    req_saddr = s;
    req_sport = sp;
    req_daddr = d;
    curr_time = t;
    req_valid = 1'b1;
    @(posedge pclk8);
    #1 req_valid = 1'b0;
    lat = 0; dp = '0; reu = 1'b0; invs = 0; icmd = 1'b0; iaddr = '0; iport = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge pclk8);
      if (rsp_valid && lat == 0) begin
        lat = c;
        dp  = rsp_dport;
        reu = rsp_reused;
      end
      if (lst_inv_valid) begin
        invs++;
        icmd  = lst_inv_cmd;
        iaddr = lst_inv_addr;
        iport = lst_inv_port;
      end
    end
  endtask

  // Issue a command and count busy cycles, invalidation pulses and stray responses.
  task automatic run_cmd(input logic [1:0] code, input int inject_at, output int busy,
                         output int invs, output int rsps, output logic icmd,
                         output logic [47:0] iaddr, output logic [PW-1:0] iport);
    @(negedge pclk8);
    cmd       = code;
    cmd_valid = 1'b1;
    @(posedge pclk8);
    #1 cmd_valid = 1'b0;
    busy = 0; invs = 0; rsps = 0; icmd = 1'b0; iaddr = '0; iport = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk8);
      cmd_valid = 1'b0;
      if (lst_inv_valid) begin
        invs++;
        icmd  = lst_inv_cmd;
        iaddr = lst_inv_addr;
        iport = lst_inv_port;
      end
      if (rsp_valid) rsps++;
      if (!cmd_busy) break;
      busy++;
      if (c == inject_at) begin
        cmd       = CMD_CLR_ALL;
        cmd_valid = 1'b1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            lat, invs, busy, rsps;
    logic [4:0]    dp;
    logic          reu, icmd;
    logic [47:0]   iaddr;
    logic [PW-1:0] iport;

    vecs[0]  = '{"flood_after_clr",  48'h0AAA,            2'd0, 48'h0BBB,           32'd100, 5'b01110, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[1]  = '{"learn_1234",       48'h1234,            2'd2, 48'h0C0C,           32'd100, 5'b01011, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[2]  = '{"hit_1234",         48'h0055,            2'd0, 48'h1234,           32'd120, 5'b00100, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[3]  = '{"aged_1234",        48'h0055,            2'd0, 48'h1234,           32'd200, 5'b01110, 1'b0, 1'b1, 48'h1234, 2'd2};
    vecs[4]  = '{"aged_again",       48'h0055,            2'd0, 48'h1234,           32'd200, 5'b01110, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[5]  = '{"learn_01",         48'h0001,            2'd1, 48'h0077,           32'd200, 5'b01101, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[6]  = '{"learn_100",        48'h0100,            2'd3, 48'h0077,           32'd200, 5'b00111, 1'b1, 1'b0, 48'h0,    2'd0};
    vecs[7]  = '{"self",             48'h0066,            2'd0, MY_MAC,             32'd200, 5'b10000, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[8]  = '{"bcast",            48'h0067,            2'd3, 48'hFFFF_FFFF_FFFF, 32'd200, 5'b00111, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[9]  = '{"own_write_filter", 48'h0042,            2'd1, 48'h0042,           32'd200, 5'b00000, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[10] = '{"skip_own_mac",     MY_MAC,              2'd0, 48'h0100,           32'd200, 5'b01000, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[11] = '{"skip_mcast",       48'h0100_0000_0000,  2'd0, 48'h0100,           32'd200, 5'b01000, 1'b0, 1'b0, 48'h0,    2'd0};
    vecs[12] = '{"hit_port1",        MY_MAC,              2'd0, 48'h0042,           32'd200, 5'b00010, 1'b0, 1'b0, 48'h0,    2'd0};

    n_p_reset8   = 1'b0;
    req_valid    = 1'b0;
    req_daddr    = '0;
    req_saddr    = '0;
    req_sport    = '0;
    mac_addr     = MY_MAC;
    best_bfr_age = 32'd50;
    curr_time    = '0;
    cmd_valid    = 1'b0;
    cmd          = 2'b00;
    clear_reused = 1'b0;

    // Reset state
    repeat (3) @(posedge pclk8);
    @(negedge pclk8);
    n_p_reset8 = 1'b1;
    check("rst_req_ready",     64'(req_ready),     64'd1);
    check("rst_cmd_busy",      64'(cmd_busy),      64'd0);
    check("rst_rsp_valid",     64'(rsp_valid),     64'd0);
    check("rst_rsp_dport",     64'(rsp_dport),     64'd0);
    check("rst_sticky",        64'(reused_sticky), 64'd0);
    check("rst_lst_inv_valid", 64'(lst_inv_valid), 64'd0);
    check("rst_lst_inv_addr",  64'(lst_inv_addr),  64'd0);

    // Clear-all sweep: busy exactly DEPTH cycles, no responses
    run_cmd(CMD_CLR_ALL, -1, busy, invs, rsps, icmd, iaddr, iport);
    check("clr_busy_cycles", 64'(busy), 64'(DEPTH));
    check("clr_no_rsp",      64'(rsps), 64'd0);
    check("clr_no_inv",      64'(invs), 64'd0);

    // Ignored command code blocks requests for that cycle but starts nothing
    @(negedge pclk8);
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    #1 check("cmd_blocks_ready", 64'(req_ready), 64'd0);
    @(negedge pclk8);
    cmd_valid = 1'b0;
    #1;
    check("ign_cmd_not_busy", 64'(cmd_busy),  64'd0);
    check("ign_cmd_ready",    64'(req_ready), 64'd1);

    // Request vectors
    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i].saddr, vecs[i].sport, vecs[i].daddr, vecs[i].ctime,
             lat, dp, reu, invs, icmd, iaddr, iport);
      check({vecs[i].name, "_latency"}, 64'(lat),  64'd5);
      check({vecs[i].name, "_dport"},   64'(dp),   64'(vecs[i].dport));
      check({vecs[i].name, "_reused"},  64'(reu),  64'(vecs[i].reused));
      check({vecs[i].name, "_invs"},    64'(invs), 64'(vecs[i].inv));
      if (vecs[i].inv) begin
        check({vecs[i].name, "_inv_cmd"},  64'(icmd),  64'd0);
        check({vecs[i].name, "_inv_addr"}, 64'(iaddr), 64'(vecs[i].inv_addr));
        check({vecs[i].name, "_inv_port"}, 64'(iport), 64'(vecs[i].inv_port));
      end
    end

    // Sticky reuse flag holds until cleared
    check("sticky_set", 64'(reused_sticky), 64'd1);
    @(negedge pclk8);
    clear_reused = 1'b1;
    @(negedge pclk8);
    clear_reused = 1'b0;
    check("sticky_cleared", 64'(reused_sticky), 64'd0);

    // Aging sweep with wrapped time
    best_bfr_age = 32'h40;
    run_cmd(CMD_CLR_ALL, -1, busy, invs, rsps, icmd, iaddr, iport);
    check("clr2_busy_cycles", 64'(busy), 64'(DEPTH));
    do_req(48'h11, 2'd1, 48'hEE, 32'hFFFF_FF00, lat, dp, reu, invs, icmd, iaddr, iport);
    check("learn_x_dport", 64'(dp), 64'b01101);
    do_req(48'h22, 2'd2, 48'hEE, 32'hFFFF_FFF0, lat, dp, reu, invs, icmd, iaddr, iport);
    check("learn_y_dport", 64'(dp), 64'b01011);
    do_req(48'h33, 2'd3, 48'hEE, 32'hFFFF_FFF0, lat, dp, reu, invs, icmd, iaddr, iport);
    check("learn_z_dport", 64'(dp), 64'b00111);
    curr_time = 32'h10;
    run_cmd(CMD_INV_AGED, 100, busy, invs, rsps, icmd, iaddr, iport);
    check("age_busy_cycles", 64'(busy),  64'(2 * DEPTH));
    check("age_inv_count",   64'(invs),  64'd1);
    check("age_inv_cmd",     64'(icmd),  64'd1);
    check("age_inv_addr",    64'(iaddr), 64'h11);
    check("age_inv_port",    64'(iport), 64'd1);
    check("age_no_rsp",      64'(rsps),  64'd0);
    do_req(MY_MAC, 2'd0, 48'h22, 32'h10, lat, dp, reu, invs, icmd, iaddr, iport);
    check("y_survives_dport", 64'(dp), 64'b00100);
    do_req(MY_MAC, 2'd0, 48'h11, 32'h10, lat, dp, reu, invs, icmd, iaddr, iport);
    check("x_gone_dport", 64'(dp),   64'b01110);
    check("x_gone_invs",  64'(invs), 64'd0);
    do_req(MY_MAC, 2'd0, 48'h33, 32'h10, lat, dp, reu, invs, icmd, iaddr, iport);
    check("z_survives_dport", 64'(dp), 64'b01000);

    // Reset in the middle of a sweep
    @(negedge pclk8);
    cmd       = CMD_INV_AGED;
    cmd_valid = 1'b1;
    @(posedge pclk8);
    #1 cmd_valid = 1'b0;
    repeat (50) @(negedge pclk8);
    check("mid_sweep_busy", 64'(cmd_busy), 64'd1);
    n_p_reset8 = 1'b0;
    @(negedge pclk8);
    n_p_reset8 = 1'b1;
    check("rst2_cmd_busy",  64'(cmd_busy),  64'd0);
    check("rst2_req_ready", 64'(req_ready), 64'd1);
    check("rst2_rsp_valid", 64'(rsp_valid), 64'd0);
    do_req(MY_MAC, 2'd0, 48'h22, 32'h10, lat, dp, reu, invs, icmd, iaddr, iport);
    check("rst2_y_latency", 64'(lat), 64'd5);
    check("rst2_y_flood",   64'(dp),  64'b01110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
